// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the delay-line slot type for the issue-stage
// scoreboard.
package pipe_pkg;

   localparam int REG_W    = 5;
   localparam int NUM_REGS = 32;

   localparam logic [1:0]       FU_Y     = 2'd3;
   localparam logic [1:0]       FU_NONE  = 2'd0;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
   } slot_t;

endpackage

// File: rtl/sb_y_delay_line.sv
// Position-based tracker for in-flight Y ops: slot i holds the op accepted
// i+1 edges ago; exposes the collision tap, the retiring slot and a popcount.
module sb_y_delay_line
   import pipe_pkg::*;
#(
   parameter int DEPTH = 5,
   parameter int TAP   = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_valid,
   input  logic [REG_W-1:0] push_rd,
   output logic             tap_valid,
   output logic             retire_valid,
   output logic [REG_W-1:0] retire_rd,
   output logic [3:0]       inflight
);

   slot_t slot_q [DEPTH];
   slot_t slot_d [DEPTH];

   always_comb begin
      slot_d[0] = '{valid: push_valid, rd: push_rd};
      for (int i = 1; i < DEPTH; i++) begin
         slot_d[i] = slot_q[i-1];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

   assign tap_valid    = slot_q[TAP].valid;
   assign retire_valid = slot_q[DEPTH-1].valid;
   assign retire_rd    = slot_q[DEPTH-1].rd;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < DEPTH; i++) begin
         inflight = inflight + 4'(slot_q[i].valid);
      end
   end

endmodule

// File: rtl/issue_y_scoreboard.sv
// Issue-stage hazard unit ahead of multiply unit Y: RAW/WAW/writeback-port stalls.
// Optional stall statistics counter enabled by SB_STALL_STATS_EN.
module issue_y_scoreboard
   import pipe_pkg::*;
#(
   parameter int Y_LATENCY = 5,
   parameter int X_LATENCY = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             id_is_valid,
   input  logic [1:0]       id_is_functionalunit,
   input  logic [REG_W-1:0] id_is_rs,
   input  logic [REG_W-1:0] id_is_rt,
   input  logic [REG_W-1:0] id_is_rd,
   input  logic             id_is_writes,
   output logic             is_id_stall,
   output logic [1:0]       is_y_functionalunit,
   output logic [REG_W-1:0] is_y_regdest,
   output logic [3:0]       sb_y_inflight,
   output logic [31:0]      sb_stall_count
);

   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic [1:0]          fu_q, fu_d;
   logic [REG_W-1:0]    regdest_q, regdest_d;

   logic             tap_valid, retire_valid;
   logic [REG_W-1:0] retire_rd;
   logic             is_y_op, raw, waw, collision, accept, yacc;

   // An X op accepted now writes back on the same edge as the Y op sitting at the tap.
   sb_y_delay_line #(
      .DEPTH (Y_LATENCY),
      .TAP   (Y_LATENCY - X_LATENCY - 1)
   ) u_delay_line (
      .clock        (clock),
      .reset        (reset),
      .push_valid   (yacc),
      .push_rd      (id_is_rd),
      .tap_valid    (tap_valid),
      .retire_valid (retire_valid),
      .retire_rd    (retire_rd),
      .inflight     (sb_y_inflight)
   );

   always_comb begin
      is_y_op     = (id_is_functionalunit == FU_Y);
      raw         = ((id_is_rs != REG_ZERO) && pending_q[id_is_rs]) ||
                    ((id_is_rt != REG_ZERO) && pending_q[id_is_rt]);
      waw         = id_is_writes && (id_is_rd != REG_ZERO) && pending_q[id_is_rd];
      collision   = !is_y_op && id_is_writes && tap_valid;
      is_id_stall = id_is_valid && (raw || waw || collision);
      accept      = id_is_valid && !is_id_stall;
      yacc        = accept && is_y_op && id_is_writes && (id_is_rd != REG_ZERO);
   end

   // Set after clear so a same-index collision resolves to set.
   always_comb begin
      pending_d = pending_q;
      if (retire_valid) begin
         pending_d[retire_rd] = 1'b0;
      end
      if (yacc) begin
         pending_d[id_is_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_comb begin
      fu_d      = FU_NONE;
      regdest_d = REG_ZERO;
      if (accept && is_y_op) begin
         fu_d      = FU_Y;
         regdest_d = id_is_rd;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending_q <= '0;
         fu_q      <= FU_NONE;
         regdest_q <= REG_ZERO;
      end else begin
         pending_q <= pending_d;
         fu_q      <= fu_d;
         regdest_q <= regdest_d;
      end
   end

   assign is_y_functionalunit = fu_q;
   assign is_y_regdest        = regdest_q;

`ifdef SB_STALL_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (is_id_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign sb_stall_count = stall_cnt_q;
`else
   assign sb_stall_count = '0;
`endif

endmodule

// File: tb/tb_issue_y_scoreboard.sv
// Directed bench for issue_y_scoreboard at Y_LATENCY=5, X_LATENCY=1.
// Cycle N below means the cycle following the Nth rising edge after the producer's accept cycle 0.
module tb_issue_y_scoreboard;

   logic        clock = 1'b0;
   logic        reset;
   logic        id_is_valid;
   logic [1:0]  id_is_functionalunit;
   logic [4:0]  id_is_rs, id_is_rt, id_is_rd;
   logic        id_is_writes;
   logic        is_id_stall;
   logic [1:0]  is_y_functionalunit;
   logic [4:0]  is_y_regdest;
   logic [3:0]  sb_y_inflight;
   logic [31:0] sb_stall_count;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_count;

   issue_y_scoreboard dut (
      .clock                (clock),
      .reset                (reset),
      .id_is_valid          (id_is_valid),
      .id_is_functionalunit (id_is_functionalunit),
      .id_is_rs             (id_is_rs),
      .id_is_rt             (id_is_rt),
      .id_is_rd             (id_is_rd),
      .id_is_writes         (id_is_writes),
      .is_id_stall          (is_id_stall),
      .is_y_functionalunit  (is_y_functionalunit),
      .is_y_regdest         (is_y_regdest),
      .sb_y_inflight        (sb_y_inflight),
      .sb_stall_count       (sb_stall_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] fu, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic wr);
      id_is_valid          = v;
      id_is_functionalunit = fu;
      id_is_rs             = rs;
      id_is_rt             = rt;
      id_is_rd             = rd;
      id_is_writes         = wr;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   initial begin
      reset = 1'b0;
      idle();
      tick();
      drive(1'b1, 2'd3, 5'd0, 5'd0, 5'd5, 1'b1);
      check("rst_stall", 32'(is_id_stall), 32'd0);
      tick();
      check("rst_fu", 32'(is_y_functionalunit), 32'd0);
      check("rst_rd", 32'(is_y_regdest), 32'd0);
      check("rst_inflight", 32'(sb_y_inflight), 32'd0);
      check("rst_count", sb_stall_count, 32'd0);
      idle();
      reset = 1'b1;
      tick();

      // RAW via rs: producer rd=5 at cycle 0, consumer stalls cycles 1..5
      drive(1'b1, 2'd3, 5'd1, 5'd2, 5'd5, 1'b1);
      check("raw_prod_stall", 32'(is_id_stall), 32'd0);
      tick();
      check("raw_prod_fu", 32'(is_y_functionalunit), 32'd3);
      check("raw_prod_rd", 32'(is_y_regdest), 32'd5);
      check("raw_inflight1", 32'(sb_y_inflight), 32'd1);
      drive(1'b1, 2'd0, 5'd5, 5'd0, 5'd8, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         check("raw_rs_stall", 32'(is_id_stall), 32'd1);
         tick();
         if (k == 1) check("raw_bubble_fu", 32'(is_y_functionalunit), 32'd0);
      end
      check("raw_rs_release", 32'(is_id_stall), 32'd0);
      tick();
      check("raw_x_fu", 32'(is_y_functionalunit), 32'd0);
      check("raw_drained", 32'(sb_y_inflight), 32'd0);

      // RAW via rt, non-writing consumer
      drive(1'b1, 2'd3, 5'd0, 5'd0, 5'd6, 1'b1);
      check("raw2_prod_stall", 32'(is_id_stall), 32'd0);
      tick();
      drive(1'b1, 2'd0, 5'd0, 5'd6, 5'd0, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         check("raw_rt_stall", 32'(is_id_stall), 32'd1);
         tick();
      end
      check("raw_rt_release", 32'(is_id_stall), 32'd0);
      tick();
      idle();
`ifdef SB_STALL_STATS_EN
      exp_count = 32'd10;
`else
      exp_count = 32'd0;
`endif
      check("stall_count", sb_stall_count, exp_count);

      // Back-to-back independent Y ops
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 2'd3, 5'd0, 5'd0, 5'(i), 1'b1);
         check("b2b_stall", 32'(is_id_stall), 32'd0);
         tick();
         check("b2b_fu", 32'(is_y_functionalunit), 32'd3);
         check("b2b_rd", 32'(is_y_regdest), 32'(i));
      end
      idle();
      check("b2b_inflight_peak", 32'(sb_y_inflight), 32'd4);
      for (int k = 1; k <= 5; k++) begin
         tick();
         check("b2b_drain", 32'(sb_y_inflight), (k == 1) ? 32'd4 : 32'(5 - k));
      end
      check("b2b_fu_idle", 32'(is_y_functionalunit), 32'd0);

      // Port collision: Y accepted cycle 0 occupies slot[3] in cycle 4
      drive(1'b1, 2'd3, 5'd0, 5'd0, 5'd12, 1'b1);
      tick();
      idle();
      tick();
      tick();
      drive(1'b1, 2'd1, 5'd0, 5'd0, 5'd9, 1'b1);
      check("col_cycle3", 32'(is_id_stall), 32'd0);
      tick();
      drive(1'b1, 2'd1, 5'd0, 5'd0, 5'd10, 1'b0);
      check("col_nowrite", 32'(is_id_stall), 32'd0);
      drive(1'b1, 2'd1, 5'd0, 5'd0, 5'd10, 1'b1);
      check("col_cycle4", 32'(is_id_stall), 32'd1);
      check("col_inflight", 32'(sb_y_inflight), 32'd1);
      tick();
      check("col_cycle5", 32'(is_id_stall), 32'd0);
      tick();
      idle();
      for (int k = 0; k < 6; k++) tick();

      // WAW on rd=7, then r0 handling
      drive(1'b1, 2'd3, 5'd0, 5'd0, 5'd7, 1'b1);
      tick();
      drive(1'b1, 2'd0, 5'd0, 5'd0, 5'd7, 1'b0);
      check("waw_nowrite", 32'(is_id_stall), 32'd0);
      drive(1'b1, 2'd0, 5'd0, 5'd0, 5'd7, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         check("waw_stall", 32'(is_id_stall), 32'd1);
         tick();
      end
      check("waw_release", 32'(is_id_stall), 32'd0);
      tick();
      drive(1'b1, 2'd3, 5'd0, 5'd0, 5'd0, 1'b1);
      check("r0_prod_stall", 32'(is_id_stall), 32'd0);
      tick();
      check("r0_fu", 32'(is_y_functionalunit), 32'd3);
      check("r0_rd", 32'(is_y_regdest), 32'd0);
      check("r0_untracked", 32'(sb_y_inflight), 32'd0);
      drive(1'b1, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1);
      check("r0_consumer", 32'(is_id_stall), 32'd0);
      tick();
      idle();

      // Reset mid-flight
      for (int i = 20; i <= 22; i++) begin
         drive(1'b1, 2'd3, 5'd0, 5'd0, 5'(i), 1'b1);
         tick();
      end
      drive(1'b1, 2'd3, 5'd22, 5'd0, 5'd23, 1'b1);
      check("mid_dep_stall", 32'(is_id_stall), 32'd1);
      check("mid_inflight", 32'(sb_y_inflight), 32'd3);
      reset = 1'b0;
      #1;
      check("mid_rst_inflight", 32'(sb_y_inflight), 32'd0);
      check("mid_rst_fu", 32'(is_y_functionalunit), 32'd0);
      check("mid_rst_rd", 32'(is_y_regdest), 32'd0);
      check("mid_rst_stall", 32'(is_id_stall), 32'd0);
      check("mid_rst_count", sb_stall_count, 32'd0);
      tick();
      reset = 1'b1;
      #1;
      check("post_rst_stall", 32'(is_id_stall), 32'd0);
      tick();
      check("post_rst_fu", 32'(is_y_functionalunit), 32'd3);
      check("post_rst_rd", 32'(is_y_regdest), 32'd23);
      idle();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
